// File: rtl/multicycle_alu.sv
// multicycle_alu: single-cycle ALU with a radix-2 shift-add multiplier.
// Ports:
//   Clk          system clock, rising edge
//   Reset_n      asynchronous active-low reset
//   Start        launches an operation on the current ALUControl/A/B
//   ALUControl   5-bit operation select, sampled on an accepted Start
//   A, B         WIDTH-bit operands, sampled on an accepted Start
//   ALUResult    registered result (low half of a product for multiplies)
//   ALUResultHi  registered high half of the last multiply
//   Zero         ALUResult == 0
//   Busy         multiply in progress
//   Done         one-cycle pulse, result registers valid
module multicycle_alu #(
  parameter int WIDTH = 32,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [4:0]       ALUControl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] ALUResult,
  output logic [WIDTH-1:0] ALUResultHi,
  output logic             Zero,
  output logic             Busy,
  output logic             Done
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [4:0] OP_ADD = 5'b00000, OP_SUB = 5'b00001, OP_MUL = 5'b00010, OP_MULU = 5'b00011;
  localparam logic [4:0] OP_BGTZ = 5'b00100, OP_BLEZ = 5'b00101, OP_BGEZ = 5'b00110, OP_BLTZ = 5'b00111;
  localparam logic [4:0] OP_AND = 5'b01000, OP_OR = 5'b01001, OP_NOR = 5'b01010, OP_XOR = 5'b01011;
  localparam logic [4:0] OP_SLL = 5'b01100, OP_SRL = 5'b01101, OP_SLT = 5'b01110, OP_SLTU = 5'b01111;
  localparam logic [4:0] OP_SRA = 5'b10000;
  typedef enum logic [1:0] {IDLE, MUL, FIN} state_t;
  state_t state, next_state;
  logic [2*WIDTH-1:0] mcand, acc, acc_step, product;
  logic [WIDTH-1:0] mplier, a_mag, b_mag, alu_res;
  logic [CW-1:0] count;
  logic neg, is_mul, is_signed, a_neg, a_zero;
  logic [SHW-1:0] sh;
  assign is_mul = (ALUControl == OP_MUL) || (ALUControl == OP_MULU);
  assign is_signed = ALUControl == OP_MUL;
  // Signed multiply works on magnitudes; the most negative value's magnitude
  // is still representable as an unsigned WIDTH-bit number.
  assign a_mag = (is_signed && A[WIDTH-1]) ? ~A + 1'b1 : A;
  assign b_mag = (is_signed && B[WIDTH-1]) ? ~B + 1'b1 : B;
  assign acc_step = acc + (mplier[0] ? mcand : '0);
  assign product = neg ? ~acc_step + 1'b1 : acc_step;
  assign sh = B[SHW-1:0];
  assign a_neg = A[WIDTH-1];
  assign a_zero = A == '0;
  always_comb begin
    alu_res = '1;
    case (ALUControl)
      OP_ADD:  alu_res = A + B;
      OP_SUB:  alu_res = A - B;
      OP_BGTZ: alu_res = {{(WIDTH-1){1'b0}}, !a_neg && !a_zero};
      OP_BLEZ: alu_res = {{(WIDTH-1){1'b0}}, a_neg || a_zero};
      OP_BGEZ: alu_res = {{(WIDTH-1){1'b0}}, !a_neg};
      OP_BLTZ: alu_res = {{(WIDTH-1){1'b0}}, a_neg};
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_NOR:  alu_res = ~(A | B);
      OP_XOR:  alu_res = A ^ B;
      OP_SLL:  alu_res = A << sh;
      OP_SRL:  alu_res = A >> sh;
      OP_SRA:  alu_res = $signed(A) >>> sh;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, A < B};
      default: alu_res = '1;
    endcase
  end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) state <= IDLE;
    else state <= next_state;
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = (Start && is_mul) ? MUL : IDLE;
      MUL:     next_state = (count == LAST) ? FIN : MUL;
      default: next_state = IDLE;
    endcase
  end
  assign Busy = state == MUL;
  assign Zero = ALUResult == '0;
  // The final partial product is folded in and sign-corrected on the edge
  // that enters FIN, so the result registers are valid while Done is high.
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      ALUResult <= '0;
      ALUResultHi <= '0;
      Done <= 1'b0;
      mcand <= '0;
      acc <= '0;
      mplier <= '0;
      count <= '0;
      neg <= 1'b0;
    end else begin
      Done <= 1'b0;
      if (state == IDLE && Start) begin
        if (is_mul) begin
          mcand <= {{WIDTH{1'b0}}, a_mag};
          mplier <= b_mag;
          acc <= '0;
          count <= '0;
          neg <= is_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
        end else begin
          ALUResult <= alu_res;
          Done <= 1'b1;
        end
      end else if (state == MUL) begin
        acc <= acc_step;
        mcand <= mcand << 1;
        mplier <= mplier >> 1;
        count <= count + 1'b1;
        if (count == LAST) begin
          {ALUResultHi, ALUResult} <= product;
          Done <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu: randomized and directed check of multicycle_alu against a behavioural model.
module tb_multicycle_alu;
  localparam int W = 32;
  logic Clk = 1'b0, Reset_n = 1'b0, Start = 1'b0;
  logic [4:0] ALUControl = '0;
  logic [W-1:0] A = '0, B = '0;
  logic [W-1:0] ALUResult, ALUResultHi;
  logic Zero, Busy, Done;
  int tests = 0, fails = 0;
  logic [W-1:0] m_lo = '0, m_hi = '0;
  multicycle_alu #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .ALUControl(ALUControl),
    .A(A), .B(B), .ALUResult(ALUResult), .ALUResultHi(ALUResultHi),
    .Zero(Zero), .Busy(Busy), .Done(Done)
  );
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic ref_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, output bit mul);
    int sa, sb;
    int unsigned sh;
    logic [63:0] p;
    sa = a;
    sb = b;
    sh = {27'b0, b[4:0]};
    mul = 0;
    case (op)
      5'd0:  m_lo = a + b;
      5'd1:  m_lo = a - b;
      5'd2:  begin p = longint'(sa) * longint'(sb); {m_hi, m_lo} = p; mul = 1; end
      5'd3:  begin p = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = p; mul = 1; end
      5'd4:  m_lo = {31'b0, sa > 0};
      5'd5:  m_lo = {31'b0, sa <= 0};
      5'd6:  m_lo = {31'b0, sa >= 0};
      5'd7:  m_lo = {31'b0, sa < 0};
      5'd8:  m_lo = a & b;
      5'd9:  m_lo = a | b;
      5'd10: m_lo = ~(a | b);
      5'd11: m_lo = a ^ b;
      5'd12: m_lo = a << sh;
      5'd13: m_lo = a >> sh;
      5'd16: m_lo = sa >>> sh;
      5'd14: m_lo = {31'b0, sa < sb};
      5'd15: m_lo = {31'b0, a < b};
      default: m_lo = 32'hFFFF_FFFF;
    endcase
  endtask
  // Issues one Start and follows it to Done. poke > 0 raises Start (with an ADD)
  // on that cycle of the operation, which must be ignored while busy.
  task automatic run(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input int poke);
    bit mul;
    int k, busy;
    ref_op(op, a, b, mul);
    @(negedge Clk);
    Start = 1'b1; ALUControl = op; A = a; B = b;
    @(negedge Clk);
    Start = 1'b0; A = $urandom; B = $urandom; ALUControl = 5'($urandom);
    k = 1;
    busy = 0;
    while (!Done && k < 100) begin
      if (Busy) busy++;
      if (k == poke) begin Start = 1'b1; ALUControl = 5'd0; end
      @(negedge Clk);
      Start = 1'b0;
      k++;
    end
    chk("latency", 64'(k), mul ? 64'd33 : 64'd1);
    chk("busy_cycles", 64'(busy), mul ? 64'd32 : 64'd0);
    chk("busy_at_done", {63'b0, Busy}, 64'd0);
    chk("result_lo", {32'b0, ALUResult}, {32'b0, m_lo});
    chk("result_hi", {32'b0, ALUResultHi}, {32'b0, m_hi});
    chk("zero", {63'b0, Zero}, {63'b0, m_lo == 0});
    @(negedge Clk);
    chk("done_pulse", {63'b0, Done}, 64'd0);
    if (poke > 0)
      repeat (3) begin
        @(negedge Clk);
        chk("extra_done", {63'b0, Done}, 64'd0);
      end
  endtask
  initial begin
    logic [31:0] ra, rb;
    logic [4:0] rop;
    repeat (3) @(negedge Clk);
    chk("rst_lo", {32'b0, ALUResult}, 64'd0);
    chk("rst_hi", {32'b0, ALUResultHi}, 64'd0);
    chk("rst_zero", {63'b0, Zero}, 64'd1);
    chk("rst_busy", {63'b0, Busy}, 64'd0);
    chk("rst_done", {63'b0, Done}, 64'd0);
    Reset_n = 1'b1;
    run(5'd0, 32'h7FFF_FFFF, 32'd1, 0);
    chk("add_ovf", {32'b0, ALUResult}, 64'h8000_0000);
    run(5'd1, 32'd5, 32'd5, 0);
    chk("sub_zero", {63'b0, Zero}, 64'd1);
    run(5'd14, 32'hFFFF_FFFF, 32'd1, 0);
    chk("slt", {32'b0, ALUResult}, 64'd1);
    run(5'd15, 32'hFFFF_FFFF, 32'd1, 0);
    chk("sltu", {32'b0, ALUResult}, 64'd0);
    run(5'd2, 32'hFFFF_FFFE, 32'd3, 0);
    chk("mul_neg", {ALUResultHi, ALUResult}, 64'hFFFF_FFFF_FFFF_FFFA);
    run(5'd3, 32'hFFFF_FFFE, 32'd3, 0);
    chk("mulu", {ALUResultHi, ALUResult}, 64'h0000_0002_FFFF_FFFA);
    run(5'd2, 32'h8000_0000, 32'h8000_0000, 5);
    chk("mul_minmin", {ALUResultHi, ALUResult}, 64'h4000_0000_0000_0000);
    run(5'd16, 32'h8000_0000, 32'h24, 0);
    chk("sra", {32'b0, ALUResult}, 64'hF800_0000);
    run(5'd13, 32'h8000_0000, 32'h24, 0);
    chk("srl", {32'b0, ALUResult}, 64'h0800_0000);
    run(5'd31, 32'd1, 32'd2, 0);
    chk("undef", {32'b0, ALUResult}, 64'hFFFF_FFFF);
    chk("hi_kept", {32'b0, ALUResultHi}, 64'h4000_0000);
    @(negedge Clk);
    Start = 1'b1; ALUControl = 5'd0; A = 32'd10; B = 32'd20;
    @(negedge Clk);
    chk("b2b_done1", {63'b0, Done}, 64'd1);
    chk("b2b_res1", {32'b0, ALUResult}, 64'd30);
    ALUControl = 5'd1; A = 32'd7; B = 32'd9;
    @(negedge Clk);
    Start = 1'b0;
    chk("b2b_done2", {63'b0, Done}, 64'd1);
    chk("b2b_res2", {32'b0, ALUResult}, 64'hFFFF_FFFE);
    m_lo = 32'hFFFF_FFFE;
    @(negedge Clk);
    chk("b2b_end", {63'b0, Done}, 64'd0);
    @(negedge Clk);
    Start = 1'b1; ALUControl = 5'd2; A = 32'h1234_5678; B = 32'h9ABC_DEF0;
    @(negedge Clk);
    Start = 1'b0;
    repeat (9) @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    chk("ar_lo", {32'b0, ALUResult}, 64'd0);
    chk("ar_hi", {32'b0, ALUResultHi}, 64'd0);
    chk("ar_zero", {63'b0, Zero}, 64'd1);
    chk("ar_busy", {63'b0, Busy}, 64'd0);
    chk("ar_done", {63'b0, Done}, 64'd0);
    m_lo = '0;
    m_hi = '0;
    repeat (3) begin
      @(negedge Clk);
      chk("ar_no_done", {62'b0, Done, Busy}, 64'd0);
    end
    Reset_n = 1'b1;
    run(5'd0, 32'd2, 32'd3, 0);
    chk("post_rst_add", {32'b0, ALUResult}, 64'd5);
    for (int i = 0; i < 40; i++) begin
      rop = 5'($urandom_range(0, 31));
      if (i % 4 == 0) rop = 5'($urandom_range(2, 3));
      case ($urandom_range(0, 3))
        0: ra = 32'h8000_0000;
        1: ra = '0;
        default: ra = $urandom;
      endcase
      rb = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : $urandom;
      run(rop, ra, rb, 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the operand and result width in bits; legal values are powers of two from 8 to 64.
REQ-002 The module SHALL have parameter SHW, default log2(WIDTH), giving the number of low bits of B used as a shift amount.
REQ-003 The module SHALL have port Clk  input  1  system clock; all state updates occur on its rising edge.
REQ-004 The module SHALL have port Reset_n  input  1  reset, asynchronous and active-low.
REQ-005 The module SHALL have port Start  input  1  request pulse that launches the operation on the current inputs.
REQ-006 The module SHALL have port ALUControl  input  5  operation select, sampled only when a Start is accepted.
REQ-007 The module SHALL have ports A and B, each input, WIDTH bits, operands sampled only when a Start is accepted.
REQ-008 The module SHALL have port ALUResult  output  WIDTH  registered result; for multiplies it carries the low half of the product.
REQ-009 The module SHALL have port ALUResultHi  output  WIDTH  registered high half of the last multiply.
REQ-010 The module SHALL have port Zero  output  1  high when ALUResult equals 0, derived combinationally from the ALUResult register.
REQ-011 The module SHALL have port Busy  output  1  high while a multiply is in progress.
REQ-012 The module SHALL have port Done  output  1  single-cycle pulse marking that the result registers are valid.

Function
REQ-013 ALUControl encodings SHALL be as follows; every other code SHALL produce all-ones in ALUResult.
- 00000 ADD, 00001 SUB, 00010 MUL (signed), 00011 MULU (unsigned)
- 00100 BGTZ (signed A>0), 00101 BLEZ (signed A<=0), 00110 BGEZ (signed A>=0), 00111 BLTZ (signed A<0)
- 01000 AND, 01001 OR, 01010 NOR, 01011 XOR
- 01100 SLL, 01101 SRL, 10000 SRA; each shifts A by B[SHW-1:0]
- 01110 SLT (signed), 01111 SLTU (unsigned)
REQ-014 ADD and SUB SHALL wrap modulo 2^WIDTH, with no overflow flag.
REQ-015 Compare and branch-test operations SHALL write 1 or 0 zero-extended into ALUResult.
REQ-016 The state machine SHALL have three states, IDLE, MUL and FIN, and SHALL reset to IDLE.
REQ-017 In IDLE with Start=1 and a non-multiply code, the module SHALL register the result at that edge and pulse Done in the following cycle, giving a latency of 1 cycle; the state SHALL remain IDLE.
REQ-018 In IDLE with Start=1 and code MUL/MULU, the module SHALL latch the operands and enter MUL.
- Busy=1 from the next cycle onward.
- Multiply is radix-2 shift-add, one bit per cycle, for WIDTH cycles.
- Then the module enters FIN, where it writes {ALUResultHi, ALUResult} and pulses Done for one cycle with Busy=0.
- FIN returns to IDLE at the next edge.
- Total latency from the Start edge to Done is WIDTH+1 cycles.
REQ-019 Signed MUL SHALL multiply operand magnitudes and negate the 2*WIDTH-bit product when sign(A) XOR sign(B) is 1; the most negative value SHALL produce a correct product.
REQ-020 Start SHALL be ignored while Busy=1 or while in FIN; it SHALL not be queued.
REQ-021 ALUResultHi SHALL change only at multiply completion, and non-multiply operations SHALL leave it unchanged.
REQ-022 ALUResult SHALL hold its value between operations; operand changes without Start SHALL have no effect.
REQ-023 Back-to-back single-cycle Starts on consecutive cycles SHALL each be accepted, each producing its own Done pulse.

Reset
REQ-024 While Reset_n=0, the module SHALL immediately force the following, independent of Clk:
- state to IDLE
- ALUResult and ALUResultHi to 0, hence Zero=1
- Busy and Done to 0
- internal multiply registers cleared
REQ-025 Reset asserted mid-multiply SHALL abort the operation with no Done pulse, and the first Start after deassertion SHALL be accepted normally.

Verification
REQ-026 The bench SHALL cover the following directed scenarios.
- Reset, then ADD A=0x7FFFFFFF, B=1 -> one cycle later ALUResult=0x80000000, Done=1 for 1 cycle, Zero=0.
- SUB A=5, B=5 -> ALUResult=0, Zero=1; then SLT A=0xFFFFFFFF, B=1 -> 1; SLTU with the same operands -> 0.
- MUL A=0xFFFFFFFE (-2), B=3 -> Busy high for 32 cycles, Done at cycle 33, {Hi,Lo}={0xFFFFFFFF, 0xFFFFFFFA}; MULU with the same operands -> {0x00000002, 0xFFFFFFFA}.
- MUL A=0x80000000, B=0x80000000 -> {0x40000000, 0x00000000}; a Start issued during Busy is ignored, and exactly one Done is seen.
- SRA A=0x80000000, B=0x24 (shift 4) -> 0xF8000000; SRL with the same operands -> 0x08000000; undefined code 11111 -> 0xFFFFFFFF.
- Reset_n pulled low at cycle 10 of a MUL -> outputs 0 immediately, no Done; after release, ADD 2+3 -> 5.
